// File: rtl/ssd_scan_scheduler.sv
// rtl/ssd_scan_scheduler.sv - 4-digit seven-segment scan controller with shared frame buffer
// Two round-robin write ports feed the buffer; one digit is driven per dwell slot after a blanking gap.
module ssd_scan_scheduler #(
  parameter int DWELL = 100000,
  parameter int GAP   = 8,
  parameter int CNT_W = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [1:0] a_digit,
  input  logic [4:0] a_value,
  input  logic       a_dp,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [1:0] b_digit,
  input  logic [4:0] b_value,
  input  logic       b_dp,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP);

  // rr_b set means requester B wins the next contended cycle
  logic             rr_b;
  logic [5:0]       fb [4];
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [6:0] seg_q;
  logic       dp_q;
  logic [3:0] en_q;
  logic       tick_q;

  logic       wr_en;
  logic [1:0] wr_digit;
  logic [5:0] wr_data;
  logic [5:0] cur;
  logic       slot_end;

  function automatic logic [6:0] glyph(input logic [4:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    if (!v[4]) begin
      case (v[3:0])
        4'h0: s = 7'b0000001;
        4'h1: s = 7'b1001111;
        4'h2: s = 7'b0010010;
        4'h3: s = 7'b0000110;
        4'h4: s = 7'b1001100;
        4'h5: s = 7'b0100100;
        4'h6: s = 7'b0100000;
        4'h7: s = 7'b0001111;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0000100;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b1100000;
        4'hC: s = 7'b0110001;
        4'hD: s = 7'b1000010;
        4'hE: s = 7'b0110000;
        default: s = 7'b0111000;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    a_ready  = a_valid && (!b_valid || !rr_b);
    b_ready  = b_valid && (!a_valid || rr_b);
    wr_en    = a_ready || b_ready;
    wr_digit = a_ready ? a_digit : b_digit;
    wr_data  = a_ready ? {a_value, a_dp} : {b_value, b_dp};
  end

  assign cur      = fb[idx];
  assign slot_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_b <= 1'b0;
      for (int i = 0; i < 4; i++) fb[i] <= 6'b100000;
    end else begin
      if (a_valid && b_valid) rr_b <= !rr_b;
      if (wr_en) fb[wr_digit] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outputs sample the buffer before this edge's write, so a write shows one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
      en_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= glyph(cur[5:1]);
      dp_q   <= cur[5] | ~cur[0];
      en_q   <= (cnt >= CNT_GAP) ? ~(4'b0001 << idx) : 4'b1111;
      tick_q <= slot_end && (idx == 2'd3);
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp                    = dp_q;
  assign {D4, D3, D2, D1}      = en_q;
  assign frame_tick            = tick_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// tb/tb_ssd_scan_scheduler.sv - scoreboard bench for ssd_scan_scheduler (DWELL=16, GAP=2)
module tb_ssd_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, a_dp, b_valid, b_ready, b_dp;
  logic [1:0] a_digit, b_digit;
  logic [4:0] a_value, b_value;
  logic       sa, sb_, sc, sd, se, sf, sg, sdp;
  logic       D1, D2, D3, D4, frame_tick;

  ssd_scan_scheduler #(.DWELL(16), .GAP(2), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_digit(a_digit), .a_value(a_value), .a_dp(a_dp),
    .b_valid(b_valid), .b_ready(b_ready), .b_digit(b_digit), .b_value(b_value), .b_dp(b_dp),
    .a(sa), .b(sb_), .c(sc), .d(sd), .e(se), .f(sf), .g(sg), .dp(sdp),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;    // 0: check at next slot start of dig; else check at that edge count
    int         dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   k = 0;
  int   last_tick = 0;
  int   ticks = 0;
  int   cc, dd;
  exp_t it;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic void push(input int kk, input int dg, input logic [6:0] s, input logic p);
    exp_t x;
    x.k = kk; x.dig = dg; x.seg = s; x.dp = p;
    sb.push_back(x);
  endfunction

  // Monitor: k counts edges since reset release; outputs after edge k reflect cnt=(k-1)%16
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      k = 0; last_tick = 0; ticks = 0;
    end else begin
      k++;
      cc = (k - 1) % 16;
      dd = ((k - 1) / 16) % 4;
      chk("enables", {28'd0, D4, D3, D2, D1}, (cc >= 2) ? {28'd0, ~(4'b0001 << dd)} : 32'hF);
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, ((k - 1) % 64) == 63});
      if (frame_tick) begin
        ticks++;
        if (last_tick != 0) chk("tick_period", k - last_tick, 64);
        last_tick = k;
      end
      if (sb.size() > 0) begin
        if ((sb[0].k != 0 && sb[0].k == k) || (sb[0].k == 0 && cc == 2 && dd == sb[0].dig)) begin
          it = sb.pop_front();
          chk("segments", {25'd0, sa, sb_, sc, sd, se, sf, sg}, {25'd0, it.seg});
          chk("dp_pin", {31'd0, sdp}, {31'd0, it.dp});
        end
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_d1(input int budget);
    for (int i = 0; i < budget && D1 !== 1'b0; i++) @(negedge clk);
    chk("d1_wait", {31'd0, D1}, 0);
  endtask

  int         ad[3] = '{1, 3, 3};
  int         av[3] = '{1, 3, 3};
  int         bd[2] = '{2, 0};
  int         bv[2] = '{2, 4};
  logic [3:0] ea = 4'b0101;
  logic [3:0] eb = 4'b1010;
  int         ai, bi;

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_digit = 0; a_value = 0; a_dp = 0;
    b_valid = 0; b_digit = 0; b_value = 0; b_dp = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_segments", {25'd0, sa, sb_, sc, sd, se, sf, sg}, 32'h7F);
    chk("reset_dp", {31'd0, sdp}, 1);
    chk("reset_enables", {28'd0, D4, D3, D2, D1}, 32'hF);
    chk("reset_tick", {31'd0, frame_tick}, 0);

    // A alone writes digit0 = 8 with dp lit
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1; a_digit = 0; a_value = 5'h08; a_dp = 1;
    #1;
    chk("a_ready_solo", {31'd0, a_ready}, 1);
    chk("b_ready_idle", {31'd0, b_ready}, 0);
    push(0, 0, 7'b0000000, 1'b0);
    push(0, 1, 7'b1111111, 1'b1);
    push(0, 2, 7'b1111111, 1'b1);
    push(0, 3, 7'b1111111, 1'b1);
    @(negedge clk);
    a_valid = 0;
    drain(150);

    // Asynchronous reset in the middle of the D1 slot
    wait_d1(100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_segments", {25'd0, sa, sb_, sc, sd, se, sf, sg}, 32'h7F);
    chk("midscan_dp", {31'd0, sdp}, 1);
    chk("midscan_enables", {28'd0, D4, D3, D2, D1}, 32'hF);
    chk("midscan_tick", {31'd0, frame_tick}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 7'b1111111, 1'b1);
    drain(100);

    // Contention: grants alternate A,B,A,B
    ai = 0; bi = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_digit = ad[ai][1:0]; a_value = av[ai][4:0]; a_dp = 0;
      b_valid = 1; b_digit = bd[bi][1:0]; b_value = bv[bi][4:0]; b_dp = 0;
      #1;
      chk("rr_a_ready", {31'd0, a_ready}, {31'd0, ea[i]});
      chk("rr_b_ready", {31'd0, b_ready}, {31'd0, eb[i]});
      if (ea[i]) ai++;
      if (eb[i]) bi++;
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
    push(0, 1, 7'b1001111, 1'b1);
    push(0, 2, 7'b0010010, 1'b1);
    push(0, 3, 7'b0000110, 1'b1);
    push(0, 0, 7'b1001100, 1'b1);
    drain(150);

    // Blank value overrides the decimal point
    b_valid = 1; b_digit = 2; b_value = 5'h13; b_dp = 1;
    #1;
    chk("b_ready_solo", {31'd0, b_ready}, 1);
    chk("a_ready_idle", {31'd0, a_ready}, 0);
    push(0, 2, 7'b1111111, 1'b1);
    @(negedge clk);
    b_valid = 0;
    drain(100);

    // Writes to the displayed digit show one cycle after acceptance
    wait_d1(100);
    a_valid = 1; a_digit = 0; a_value = 5'h01; a_dp = 0;
    #1;
    chk("a_ready_live", {31'd0, a_ready}, 1);
    push(k + 2, 0, 7'b1001111, 1'b1);
    @(negedge clk);
    a_value = 5'h00;
    push(k + 2, 0, 7'b0000001, 1'b1);
    @(negedge clk);
    a_valid = 0;
    drain(10);

    // Free run for three frames
    repeat (3 * 64 + 8) @(negedge clk);
    chk("tick_count", {31'd0, ticks >= 3}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ssd_scan_scheduler.md
# ssd_scan_scheduler

Scan controller and shared frame buffer for the 4-digit multiplexed seven-segment display. Holds one 5-bit value plus decimal point per digit and arbitrates writes from two requesters with round-robin. Drives one digit at a time for a programmable dwell, with a blanking gap before each digit to suppress ghosting. Sits between producer logic (counters, scrollers) and the board pins, and emits a frame tick that producers use for pacing.

## Interface
- DWELL, 100000: clock cycles per digit slot; legal range GAP+2 .. 2^CNT_W-1.
- GAP, 8: cycles at the start of each slot with all digits off; legal range 1 .. DWELL-2.
- CNT_W, 17: width of the dwell counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- a_valid  in  1  requester A write request.
- a_ready  out  1  A granted this cycle; combinational.
- a_digit  in  2  A target digit index; index 0 is D1.
- a_value  in  5  A value; bit4=1 blanks the digit, otherwise bits[3:0] are a hex nibble.
- a_dp  in  1  A decimal point; 1 = lit.
- b_valid, b_ready, b_digit, b_value, b_dp  as A, for requester B.
- a, b, c, d, e, f, g, dp  out  1 each  segment drives, active-low; registered.
- D1, D2, D3, D4  out  1 each  digit enables, active-low; registered.
- frame_tick  out  1  one-cycle pulse per completed 4-digit scan; registered.

## Operation
- Frame buffer: 4 entries of {value[4:0], dp}. Reset value for every entry is blank, dp off.
- Arbitration: the round-robin pointer resets to A.
  - Only one requester valid: it gets ready.
  - Both valid: the pointer side gets ready, and the pointer flips to the other side after that grant.
  - A transfer is valid&&ready. The entry is written on that edge.
  - The loser holds its request; it is served on the next cycle.
  - At most one write per cycle.
  - Requester inputs must be stable while valid && !ready.
- Scan counter cnt (CNT_W bits) and digit index idx (2 bits) both reset to 0.
  - cnt increments every cycle.
  - At cnt==DWELL-1: cnt<=0 and idx<=idx+1, wrapping 3->0.
- Output register update on every edge:
  - Digit enables: if cnt>=GAP, the enable for idx is low and all others are high; otherwise all four are high.
  - Segments: decode of buffer[idx] as currently stored.
  - frame_tick: 1 iff cnt==DWELL-1 and idx==3.
- Decode, as {a,b,c,d,e,f,g} active-low, standard hex glyphs:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111
  - dp pin = ~dp_bit, forced to 1 when value bit4=1.
- No other modes. Out-of-range parameters are not supported.

## Timing
- Reset (async assert): all segment pins 1, D1..D4 = 1, frame_tick 0, buffer blank, cnt/idx/pointer 0. Takes effect immediately, including mid-scan and mid-arbitration. A pending request is dropped from the block's view and must be re-presented.
- After rst_n deasserts, the first enable is D1 low, appearing after the edge where cnt==GAP; that is, in the cycle after cnt reaches GAP.
- Write latency: a transfer accepted at edge N updates the buffer at N. If that digit is being scanned, the pins change at edge N+1. Otherwise the new glyph appears when that digit is next scanned.
- Segment pins may change during the gap; they must never change while an enable is low, except by a write to the displayed digit.
- Frame period is 4*DWELL cycles. frame_tick is high exactly one cycle per frame, in the cycle after the 3->0 wrap edge.
- Both requesters writing the same digit on consecutive grants: last-granted value wins.
- ready depends only on valid inputs and the pointer; there is no path from ready back to valid.

## Test plan
- Reset: DWELL=16, GAP=2; hold rst_n low mid-scan -> all pins 1 and frame_tick 0 immediately; after release, D1 first goes low in the cycle after cnt reaches 2, and stays low 14 cycles.
- Write A digit0 value 5'h08 dp=1, B idle -> a_ready=1 same cycle; next D1 slot shows a..g=0000000, dp=0; other slots 1111111/1.
- Both valid for 4 cycles, writing distinct digits -> grants A,B,A,B; both pointer states are exercised; no write lost.
- Write value 5'h13 dp=1 to digit2 -> D3 slot shows all segments 1 and dp=1 (blank overrides dp).
- Write digit0 while D1 is enabled, value 1 then 0 -> pins go 1001111 then 0000001, each one cycle after its accepting edge.
- Free-run 3 frames -> frame_tick pulses every 64 cycles, one cycle wide; enable order D1,D2,D3,D4; never two enables low at once.
